neuron_layer_driver: RTL and testbench

- Initiator side of the neuron handshake. It accepts one feature vector from upstream on a valid/ready interface and holds it on the neuron input bus.
- It sequences the neuron array through its fixed state walk by driving En and Run, then captures the neuron Y outputs.
- It selects the winning class with a signed argmax and returns class and score downstream on a valid/ready interface.
- It sits between the sample source and the Iris network output layer.

---
 rtl/neuron_layer_driver_if.sv | 33 +++
 rtl/neuron_layer_driver.sv | 176 +++++++++++++++++
 tb/tb_neuron_layer_driver.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_driver_if.sv
// Bundle of the sample, neuron and result buses between the layer driver and
// its neighbours. The driver uses the master view; the neuron array, sample
// source and result sink together form the slave view.
interface neuron_layer_driver_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 3
);
  localparam int CLS_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_IN*DATA_WIDTH-1:0]  in_x;
  logic                          neu_en;
  logic                          neu_run;
  logic [NUM_IN*DATA_WIDTH-1:0]  neu_x;
  logic [NUM_OUT*DATA_WIDTH-1:0] neu_y;
  logic                          out_valid;
  logic                          out_ready;
  logic [CLS_W-1:0]              out_class;
  logic [DATA_WIDTH-1:0]         out_score;
  logic                          busy;

  modport master (
    input  in_valid, in_x, neu_y, out_ready,
    output in_ready, neu_en, neu_run, neu_x, out_valid, out_class, out_score, busy
  );

  modport slave (
    output in_valid, in_x, neu_y, out_ready,
    input  in_ready, neu_en, neu_run, neu_x, out_valid, out_class, out_score, busy
  );
endinterface

// File: rtl/neuron_layer_driver.sv
// Layer driver: takes one feature vector, walks the neuron array through its
// fixed En sequence, captures the Y outputs, picks the signed argmax and hands
// class/score downstream. All outputs are registered and decoded from the
// next state, so they line up with the state they describe.
module neuron_layer_driver #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_IN       = 4,
  parameter int NUM_OUT      = 3,
  parameter int NEURON_STEPS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  neuron_layer_driver_if.master bus
);
  localparam int CLS_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;
  localparam int CNT_W = $clog2(NEURON_STEPS + 1);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(NEURON_STEPS);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NEURON_STEPS - 1);
  localparam logic [CLS_W-1:0] K_LAST     = CLS_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {S_PRIME, S_IDLE, S_RUN, S_CAPTURE, S_ARGMAX, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CLS_W-1:0]             k_q, k_d;
  logic                         neu_en_q, neu_en_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;
  logic                         neu_run_q;
  logic [NUM_IN*DATA_WIDTH-1:0] neu_x_q, neu_x_d;
  logic signed [DATA_WIDTH-1:0] y_slice [NUM_OUT];
  logic signed [DATA_WIDTH-1:0] score_q [NUM_OUT];
  logic signed [DATA_WIDTH-1:0] score_d [NUM_OUT];
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [CLS_W-1:0]             idx_q, idx_d;
  logic [CLS_W-1:0]             out_class_q, out_class_d;
  logic signed [DATA_WIDTH-1:0] out_score_q, out_score_d;

  // Comparison step for the current argmax candidate; strict > keeps the
  // lower index on ties.
  logic signed [DATA_WIDTH-1:0] cand;
  logic                         take;
  logic signed [DATA_WIDTH-1:0] win_best;
  logic [CLS_W-1:0]             win_idx;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_y
    assign y_slice[gi] = bus.neu_y[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cand     = score_q[k_q];
  assign take     = cand > best_q;
  assign win_best = take ? cand : best_q;
  assign win_idx  = take ? k_q : idx_q;

  // Next-state and next-output decode for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    neu_x_d     = neu_x_q;
    score_d     = score_q;
    best_d      = best_q;
    idx_d       = idx_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    neu_en_d    = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      S_PRIME: begin
        // The reset cycle itself has En low, so the walk spans counts 1..N.
        if (cnt_q == PRIME_LAST) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          in_ready_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          neu_en_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          neu_x_d  = bus.in_x;
          state_d  = S_RUN;
          cnt_d    = '0;
          neu_en_d = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          neu_en_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        for (int i = 0; i < NUM_OUT; i++) score_d[i] = y_slice[i];
        best_d  = y_slice[0];
        idx_d   = '0;
        k_d     = CLS_W'(1);
        state_d = S_ARGMAX;
      end
      S_ARGMAX: begin
        best_d = win_best;
        idx_d  = win_idx;
        if (k_q == K_LAST) begin
          out_class_d = win_idx;
          out_score_d = win_best;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          k_d = k_q + CLS_W'(1);
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_PRIME;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs; reset restarts the prime walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PRIME;
      cnt_q       <= '0;
      k_q         <= '0;
      neu_en_q    <= 1'b0;
      neu_run_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      neu_x_q     <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      out_class_q <= '0;
      out_score_q <= '0;
      for (int i = 0; i < NUM_OUT; i++) score_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      neu_en_q    <= neu_en_d;
      neu_run_q   <= 1'b1;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      neu_x_q     <= neu_x_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      for (int i = 0; i < NUM_OUT; i++) score_q[i] <= score_d[i];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.neu_en    = neu_en_q;
  assign bus.neu_run   = neu_run_q;
  assign bus.neu_x     = neu_x_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_neuron_layer_driver.sv
// Bench for neuron_layer_driver: a timestamp-based model predicts every output
// each cycle from the accept/handshake/reset history; directed cases pin the
// model with literal expectations, then a randomized phase runs against it.
module tb_neuron_layer_driver;
  localparam int DW = 8;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  neuron_layer_driver_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO)) bus ();

  neuron_layer_driver #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .NEURON_STEPS(7)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state (all cycle numbers are absolute cycle indices).
  int  cyc = 0;
  bit  started = 0;
  int  m_R = 0;
  int  m_ready_from = INF;
  int  m_acc_t = -1;
  int  m_hs_cycle = -1;
  int  m_acc_count = 0;
  bit  m_pend = 0;
  logic [NI*DW-1:0] m_x = '0;
  int  cur_scores [NO];
  int  next_scores [NO];
  int  m_cls = 0, m_sc = 0, m_last_cls = 0, m_last_sc = 0;
  bit  rand_ready = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, $signed(act), $signed(exp));
    end
  endfunction

  // Model update at each active edge, from bench-driven inputs only.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      started      = 1;
      m_R          = cyc + 1;
      m_ready_from = cyc + 9;
      m_acc_t      = -1;
      m_pend       = 0;
      m_x          = '0;
      m_last_cls   = 0;
      m_last_sc    = 0;
    end else if (started) begin
      if (cyc >= m_ready_from && bus.in_valid === 1'b1) begin
        m_acc_t      = cyc;
        m_ready_from = INF;
        m_pend       = 1;
        m_x          = bus.in_x;
        cur_scores   = next_scores;
        m_cls        = 0;
        m_sc         = cur_scores[0];
        for (int i = 1; i < NO; i++)
          if (cur_scores[i] > m_sc) begin m_sc = cur_scores[i]; m_cls = i; end
        m_acc_count++;
      end else if (m_pend && cyc >= m_acc_t + 11 && bus.out_ready === 1'b1) begin
        m_pend       = 0;
        m_ready_from = cyc + 1;
        m_hs_cycle   = cyc;
        m_last_cls   = m_cls;
        m_last_sc    = m_sc;
      end
    end
    cyc++;
  end

  // Neuron model drive plus per-cycle comparison of every output.
  initial forever begin
    logic [NO*DW-1:0] ny;
    bit e_ready, e_en, e_val;
    @(negedge clk);
    ny = (NO*DW)'($urandom);
    if (started && m_pend && cyc == m_acc_t + 8)
      for (int i = 0; i < NO; i++) ny[i*DW +: DW] = cur_scores[i][DW-1:0];
    bus.neu_y = ny;
    if (started) begin
      e_ready = (cyc >= m_ready_from);
      e_en    = (cyc >= m_R + 1 && cyc <= m_R + 7) ||
                (m_acc_t >= 0 && cyc >= m_acc_t + 1 && cyc <= m_acc_t + 7);
      e_val   = m_pend && (cyc >= m_acc_t + 11);
      chk("in_ready",  64'(bus.in_ready),  64'(e_ready));
      chk("busy",      64'(bus.busy),      64'(!e_ready));
      chk("neu_en",    64'(bus.neu_en),    64'(e_en));
      chk("neu_run",   64'(bus.neu_run),   64'(cyc > m_R));
      chk("out_valid", 64'(bus.out_valid), 64'(e_val));
      chk("neu_x",     64'(bus.neu_x),     64'(m_x));
      if (!(m_pend && !e_val)) begin
        chk("out_class", 64'(bus.out_class), 64'(e_val ? m_cls : m_last_cls));
        chk("out_score", 64'($signed(bus.out_score)), 64'(e_val ? m_sc : m_last_sc));
      end
    end
  end

  // Random downstream backpressure during the randomized phase.
  initial forever begin
    @(negedge clk);
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [NI*DW-1:0] x, input int s0, input int s1, input int s2,
                      input bit drop);
    int n, k;
    next_scores = '{s0, s1, s2};
    bus.in_x     = x;
    bus.in_valid = 1'b1;
    n = m_acc_count;
    k = 0;
    while (m_acc_count == n && k < 200) begin @(negedge clk); k++; end
    if (m_acc_count == n) chk("accept_timeout", 64'(0), 64'(1));
    if (drop) bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int cls, input int sc);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk({nm, "_latency"}, 64'(cyc - m_acc_t), 64'(11));
    chk({nm, "_class"}, 64'(bus.out_class), 64'(cls));
    chk({nm, "_score"}, 64'($signed(bus.out_score)), 64'(sc));
  endtask

  task automatic prime_check(input string nm);
    int k = 0;
    int n_en = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      if (bus.neu_en === 1'b1) n_en++;
      @(negedge clk);
      k++;
    end
    chk({nm, "_en_cycles"}, 64'(n_en), 64'(7));
    chk({nm, "_ready_cycle"}, 64'(cyc - m_R), 64'(8));
  endtask

  function automatic int rscore();
    byte b;
    case ($urandom_range(0, 3))
      0: return -128;
      1: return 127;
      2: return int'($urandom_range(0, 4)) - 2;
      default: begin b = byte'($urandom); return int'(b); end
    endcase
  endfunction

  initial begin
    logic [NI*DW-1:0] x;
    int prev_t, k;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    bus.neu_y     = '0;
    next_scores   = '{0, 0, 0};
    cur_scores    = '{0, 0, 0};

    // Prime sequence after a 2-cycle reset.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prime_check("prime");

    // Basic classify.
    x = NI*DW'($urandom);
    send(x, 10, 25, -3, 1);
    chk("neu_x_t1", 64'(bus.neu_x), 64'(x));
    wait_result("basic", 1, 25);

    // Signed compare and ties.
    send(NI*DW'($urandom), 7, 7, 7, 1);
    wait_result("tieA", 0, 7);
    send(NI*DW'($urandom), -5, -2, -9, 1);
    wait_result("negB", 1, -2);
    send(NI*DW'($urandom), -128, 127, 127, 1);
    wait_result("extC", 1, 127);

    // Backpressure with a second sample waiting.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(NI*DW'($urandom), 3, -4, 9, 0);
    bus.in_x    = NI*DW'($urandom);
    next_scores = '{-1, -1, 0};
    wait_result("bp1", 2, 9);
    repeat (5) @(negedge clk);
    bus.out_ready = 1'b1;
    k = m_acc_count;
    for (int i = 0; i < 20 && m_acc_count == k; i++) @(negedge clk);
    chk("bp_accept_gap", 64'(m_acc_t - m_hs_cycle), 64'(1));
    bus.in_valid = 1'b0;
    wait_result("bp2", 2, 0);

    // Reset in the 4th RUN cycle.
    send(NI*DW'($urandom), 4, 2, 1, 1);
    for (int i = 0; i < 20 && cyc != m_acc_t + 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prime_check("rst_prime");
    send(NI*DW'($urandom), -3, -3, -4, 1);
    wait_result("post_rst", 0, -3);

    // Back-to-back samples.
    send(NI*DW'($urandom), 1, 2, 3, 0);
    prev_t = m_acc_t;
    send(NI*DW'($urandom), 9, -9, 9, 0);
    chk("b2b_gap1", 64'(m_acc_t - prev_t), 64'(12));
    prev_t = m_acc_t;
    send(NI*DW'($urandom), -7, -6, -6, 1);
    chk("b2b_gap2", 64'(m_acc_t - prev_t), 64'(12));
    wait_result("b2b3", 1, -6);

    // Randomized phase.
    rand_ready = 1;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(NI*DW'($urandom), rscore(), rscore(), rscore(), 1);
    end
    @(negedge clk);
    rand_ready    = 0;
    bus.out_ready = 1'b1;
    k = 0;
    while (m_pend && k < 50) begin @(negedge clk); k++; end
    if (m_pend) chk("drain_timeout", 64'(0), 64'(1));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
